instr_fetch_queue: RTL and testbench

Instruction fetch queue sitting directly upstream of the CPU decode path: it issues sequential word fetches to a variable-latency instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the decoder under a valid/ready handshake. Branch, jump and jr redirects from the CPU flush the queue, and any in-flight stale response is discarded. This replaces the direct PC→Instr_Memory combinational path when instruction memory gains wait states.

---
 rtl/ifq_pkg.sv | 9 +
 rtl/ifq_fifo.sv | 43 ++++
 rtl/instr_fetch_queue.sv | 100 ++++++++++
 tb/tb_instr_fetch_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared entry type, fetch FSM states and PC step for the instruction fetch queue
package ifq_pkg;
    localparam logic [31:0] PC_INCR = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} ifq_state_e;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of fetched {pc, instr} with synchronous flush
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  ifq_entry_t    wdata_i,
    output ifq_entry_t    rdata_o,
    output logic [CW-1:0] count_o
);
    ifq_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push_i);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop_i);
        count_d  = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // Storage needs no reset: the top never exposes an entry while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding sequential fetcher feeding a decoder FIFO with redirect flush.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    ifq_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic          req_q, req_d, ack, push, pop, fifo_valid;
    logic [CW-1:0] count, count_nxt;
    ifq_entry_t    head, wdata;

    assign ack        = req_q & imem_ack_i;
    assign fifo_valid = count != '0;
    assign pop        = fifo_valid & instr_ready_i & ~redirect_i;
    assign wdata      = '{pc: addr_q, instr: imem_data_i};
`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass        = ~fifo_valid & (state_q == REQ) & ack & ~redirect_i;
    assign push          = (state_q == REQ) & ack & ~redirect_i & ~(bypass & instr_ready_i);
    assign instr_valid_o = fifo_valid | bypass;
    assign instr_o       = bypass ? imem_data_i : fifo_valid ? head.instr : '0;
    assign pc_o          = bypass ? addr_q : fifo_valid ? head.pc : '0;
`else
    assign push          = (state_q == REQ) & ack & ~redirect_i;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_valid ? head.instr : '0;
    assign pc_o          = fifo_valid ? head.pc : '0;
`endif
    assign pc_next_o   = pc_o + PC_INCR;
    assign count_nxt   = count + CW'(push) - CW'(pop);
    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;

    // A request is only issued once a slot is guaranteed, so an ack never overflows the FIFO.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE:    state_d = count_nxt < FULL ? REQ : IDLE;
            REQ: begin
                if (ack) begin
                    fetch_pc_d = fetch_pc_q + PC_INCR;
                    state_d    = count_nxt < FULL ? REQ : IDLE;
                end
            end
            DISCARD: state_d = ack ? REQ : DISCARD;
            default: state_d = IDLE;
        endcase
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = (state_q != IDLE && !ack) ? DISCARD : REQ;
        end
        addr_d = state_d == DISCARD ? addr_q : fetch_pc_d;
        req_d  = state_d != IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count)
    );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed + random fetch traffic checked against an expected-stream queue model
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        imem_req_o, imem_ack_i, instr_valid_o, instr_ready_i, redirect_i;
    logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_o, pc_next_o, redirect_pc_i;

    int          tests = 0, fails = 0;
    ent_t        q[$];
    logic [31:0] m_fetch, last_addr;
    logic        stale, was_pending;
    int          wait_cfg, wait_left, acc_n, n;
    bit          rand_wait;

    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_vals(input string p);
        chk({p, "_req"}, 32'(imem_req_o), 32'd0);
        chk({p, "_addr"}, imem_addr_o, RESET_PC);
        chk({p, "_valid"}, 32'(instr_valid_o), 32'd0);
        chk({p, "_instr"}, instr_o, 32'd0);
        chk({p, "_pc"}, pc_o, 32'd0);
        chk({p, "_pc_next"}, pc_next_o, 32'd4);
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch     = RESET_PC;
        stale       = 1'b0;
        was_pending = 1'b0;
        last_addr   = RESET_PC;
        wait_left   = wait_cfg;
        acc_n       = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
        #1 reset_vals("rst");
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Called mid-cycle with this cycle's inputs set: respond, check, advance the model, then clock.
    task automatic cycle();
        bit pop;
        if (imem_req_o && wait_left == 0) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(imem_addr_o);
        end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = $urandom;
        end
        if (was_pending && imem_req_o) chk("addr_stable", imem_addr_o, last_addr);
        chk("valid", 32'(instr_valid_o), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("head_pc", pc_o, q[0].pc);
            chk("head_instr", instr_o, q[0].instr);
            chk("head_pc_next", pc_next_o, q[0].pc + 32'd4);
        end
        if (q.size() == DEPTH) chk("req_when_full", 32'(imem_req_o), 32'd0);
        if (imem_req_o && !stale) chk("fetch_addr", imem_addr_o, m_fetch);
        pop = q.size() > 0 && instr_ready_i && !redirect_i;
        if (redirect_i) begin
            q.delete();
            stale   = imem_req_o && !imem_ack_i;
            m_fetch = redirect_pc_i;
        end else begin
            if (pop) void'(q.pop_front());
            if (imem_req_o && imem_ack_i) begin
                if (stale) stale = 1'b0;
                else begin
                    chk("space_reserved", 32'(q.size() < DEPTH), 32'd1);
                    q.push_back('{pc: m_fetch, instr: mem_word(m_fetch)});
                    m_fetch += 32'd4;
                    acc_n++;
                end
            end
        end
        was_pending = imem_req_o && !imem_ack_i;
        last_addr   = imem_addr_o;
        if (imem_req_o)
            wait_left = imem_ack_i ? (rand_wait ? int'($urandom_range(3, 0)) : wait_cfg) : wait_left - 1;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_ack_i = 0; imem_data_i = 0; instr_ready_i = 0;
        redirect_i = 0; redirect_pc_i = 0; rand_wait = 0; wait_cfg = 0;
        @(negedge clk_i);

        // zero-wait streaming
        wait_cfg = 0; instr_ready_i = 1;
        do_reset();
        cycle();
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, RESET_PC);
        cycle();
        chk("seq0_pc", pc_o, 32'h100);
        chk("seq0_instr", instr_o, mem_word(32'h100));
        cycle();
        chk("seq1_pc", pc_o, 32'h104);
        cycle();
        chk("seq2_pc", pc_o, 32'h108);
        repeat (20) begin
            cycle();
            chk("sustain_valid", 32'(instr_valid_o), 32'd1);
        end

        // 3 wait states, decoder stalled: exactly DEPTH fetches
        wait_cfg = 3; instr_ready_i = 0;
        do_reset();
        repeat (40) cycle();
        chk("fill_count", acc_n, DEPTH);
        chk("idle_when_full", 32'(imem_req_o), 32'd0);
        instr_ready_i = 1;
        n = 0;
        while (!imem_req_o && n < 20) begin cycle(); n++; end
        chk("resume_req", 32'(imem_req_o), 32'd1);
        chk("resume_addr", imem_addr_o, 32'h110);

        // redirect with request to 0x10C outstanding
        wait_cfg = 3; instr_ready_i = 0;
        do_reset();
        n = 0;
        while (!(imem_req_o && imem_addr_o == 32'h10C) && n < 40) begin cycle(); n++; end
        chk("reach_10c", imem_addr_o, 32'h10C);
        wait_left = 2; redirect_i = 1; redirect_pc_i = 32'h400;
        cycle();
        redirect_i = 0;
        chk("flush_valid", 32'(instr_valid_o), 32'd0);
        chk("stale_req", 32'(imem_req_o), 32'd1);
        chk("stale_addr", imem_addr_o, 32'h10C);
        n = 0;
        while (!(imem_req_o && imem_addr_o == 32'h400) && n < 20) begin cycle(); n++; end
        chk("redirect_addr", imem_addr_o, 32'h400);
        instr_ready_i = 1;
        n = 0;
        while (!instr_valid_o && n < 20) begin cycle(); n++; end
        chk("redirect_first_pc", pc_o, 32'h400);
        repeat (10) cycle();

        // redirect coincident with ack and pop
        wait_cfg = 0; instr_ready_i = 1;
        do_reset();
        repeat (6) cycle();
        chk("coincide_pre", 32'(instr_valid_o && imem_req_o && wait_left == 0), 32'd1);
        redirect_i = 1; redirect_pc_i = 32'h400;
        cycle();
        redirect_i = 0;
        chk("coincide_valid", 32'(instr_valid_o), 32'd0);
        chk("coincide_req", 32'(imem_req_o), 32'd1);
        chk("coincide_addr", imem_addr_o, 32'h400);
        repeat (10) cycle();

        // address wrap at 2^32
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        redirect_i = 0;
        n = 0;
        while (!(instr_valid_o && pc_o == 32'hFFFF_FFFC) && n < 20) begin cycle(); n++; end
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next_o, 32'h0);
        cycle();
        chk("wrap_zero_pc", pc_o, 32'h0);
        repeat (5) cycle();

        // random traffic
        rand_wait = 1;
        repeat (3000) begin
            instr_ready_i = 1'($urandom_range(1, 0));
            redirect_i    = $urandom_range(15, 0) == 0;
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        redirect_i = 0;

        // reset while discarding a stale response
        rand_wait = 0; wait_cfg = 5; instr_ready_i = 0;
        n = 0;
        while (!imem_req_o && n < 20) begin cycle(); n++; end
        wait_left = 5; redirect_i = 1; redirect_pc_i = 32'h800;
        cycle();
        redirect_i = 0;
        chk("discard_req", 32'(imem_req_o), 32'd1);
        #2 rst_i = 1; imem_ack_i = 0;
        #1 reset_vals("mid_rst");
        wait_cfg = 0; instr_ready_i = 1;
        model_reset();
        @(negedge clk_i);
        rst_i = 0;
        cycle();
        chk("restart_req", 32'(imem_req_o), 32'd1);
        chk("restart_addr", imem_addr_o, RESET_PC);
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
